// File: rtl/uart_cmd_rx_if.sv
// uart_cmd_rx_if: serial line, consumer acknowledge and decoded outputs of the UART command receiver
interface uart_cmd_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       cmd_go;
    logic       cmd_stop;
    logic       frame_err;
    modport slave (input RX, clr_rdy, output rx_data, rdy, cmd_go, cmd_stop, frame_err);
    modport master(output RX, clr_rdy, input rx_data, rdy, cmd_go, cmd_stop, frame_err);
endinterface

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver decoding 'G'/'S' commands; optional stop-bit check via UART_CMD_RX_FRAME_ERR_EN
module uart_cmd_rx #(
    parameter int BAUD_DIV = 2604
) (
    input logic          clk,
    input logic          rst,
    uart_cmd_rx_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
`ifdef UART_CMD_RX_FRAME_ERR_EN
    localparam logic [2:0] S_WAIT  = 3'd4;
`endif
    // loads are one less than the period so that expiry lands exactly N cycles after the load
    localparam logic [11:0] L_FULL = 12'(BAUD_DIV - 1);
    localparam logic [11:0] L_HALF = 12'(BAUD_DIV / 2 - 1);

    logic        r_rx_m, r_rx_s;
    logic [1:0]  r_vld;
    logic        r_armed;
    logic [2:0]  r_state;
    logic [11:0] r_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rdy, r_go, r_stop;
    logic        w_exp, w_start, w_stop_ok, w_accept;

    assign w_exp   = r_cnt == 12'd0;
    // a start is only taken once the line has been seen genuinely high, so a line held low through reset is ignored
    assign w_start = r_state == S_IDLE && r_armed && !r_rx_s;
`ifdef UART_CMD_RX_FRAME_ERR_EN
    assign w_stop_ok = r_rx_s;
`else
    assign w_stop_ok = 1'b1;
`endif
    assign w_accept = r_state == S_STOP && w_exp && w_stop_ok;

    // two-flop synchronizer; r_vld marks when rx_s reflects real line samples rather than reset values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
            r_vld  <= 2'b00;
        end else begin
            r_rx_m <= bus.RX;
            r_rx_s <= r_rx_m;
            r_vld  <= {r_vld[0], 1'b1};
        end
    end

    // frame sequencer: mid-bit sampling driven by the baud down-counter, frozen while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 12'd0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_armed   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_vld[1] && r_rx_s) r_armed <= 1'b1;
                    if (w_start) begin
                        r_cnt   <= L_HALF;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (!w_exp) r_cnt <= r_cnt - 12'd1;
                    else if (r_rx_s) r_state <= S_IDLE;
                    else begin
                        r_cnt     <= L_FULL;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!w_exp) r_cnt <= r_cnt - 12'd1;
                    else begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_cnt     <= L_FULL;
                        if (r_bit_cnt == 4'd7) r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!w_exp) r_cnt <= r_cnt - 12'd1;
                    else begin
                        // a low stop sample must see the line return high before another start is accepted
                        r_armed <= r_rx_s;
`ifdef UART_CMD_RX_FRAME_ERR_EN
                        r_state <= r_rx_s ? S_IDLE : S_WAIT;
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
`ifdef UART_CMD_RX_FRAME_ERR_EN
                S_WAIT: if (r_rx_s) r_state <= S_IDLE;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // output register: data/flag update on accepted stop, set of rdy wins over any clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data <= 8'h00;
            r_rdy     <= 1'b0;
            r_go      <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            if (w_accept) r_rx_data <= r_shift;
            r_rdy  <= w_accept | (r_rdy & ~bus.clr_rdy & ~w_start);
            r_go   <= w_accept && r_shift == 8'h47;
            r_stop <= w_accept && r_shift == 8'h53;
        end
    end

`ifdef UART_CMD_RX_FRAME_ERR_EN
    logic r_ferr;
    // frame error pulse on a low stop sample
    always_ff @(posedge clk) begin
        if (rst) r_ferr <= 1'b0;
        else     r_ferr <= r_state == S_STOP && w_exp && !r_rx_s;
    end
    assign bus.frame_err = r_ferr;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.rx_data  = r_rx_data;
    assign bus.rdy      = r_rdy;
    assign bus.cmd_go   = r_go;
    assign bus.cmd_stop = r_stop;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: scoreboard bench for uart_cmd_rx (honours UART_CMD_RX_FRAME_ERR_EN)
module tb_uart_cmd_rx;
    localparam int BAUD = 64;
    localparam int LAT_MAX = BAUD / 2 + 9 * BAUD + 4;

    typedef struct packed {
        logic [7:0] d;
        logic       rdy;
        logic       go;
        logic       stop;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ev_cnt = 0;
    int   ev_cyc = 0;
    int   c0 = 0;
    int   lat = 0;
    int   ev_before = 0;
    exp_t q[$];

    uart_cmd_rx_if bus();

    uart_cmd_rx #(.BAUD_DIV(BAUD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.RX = 1'b1;
        bus.clr_rdy = 1'b0;
        repeat (n) tick();
    endtask

    // full 8N1 frame; clr_off>0 raises clr_rdy for the edge clr_off cycles after the falling edge
    task automatic send(input logic [7:0] d, input logic stop_bit, input int clr_off);
        logic bv;
        c0 = cyc;
        for (int b = 0; b < 10; b++) begin
            bv = (b == 0) ? 1'b0 : (b == 9) ? stop_bit : d[b-1];
            for (int k = 0; k < BAUD; k++) begin
                bus.RX = bv;
                bus.clr_rdy = (clr_off > 0 && cyc == c0 + clr_off - 1);
                tick();
            end
        end
        idle(2 * BAUD);
    endtask

    task automatic push(input logic [7:0] d, input logic r, input logic g, input logic s, input logic f);
        exp_t e;
        e.d = d; e.rdy = r; e.go = g; e.stop = s; e.ferr = f;
        q.push_back(e);
    endtask

    task automatic clear_rdy();
        bus.clr_rdy = 1'b1;
        tick();
        bus.clr_rdy = 1'b0;
        tick();
    endtask

    // monitor: every output event pops one expectation; pulses must drop after one cycle
    logic [7:0] p_data;
    logic       p_rdy, p_pulse, p_rst;
    initial begin
        exp_t e;
        p_rst = 1'b1;
        p_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && !p_rst) begin
                if (p_pulse) chk("pulse_width", {bus.cmd_go, bus.cmd_stop, bus.frame_err}, 3'b000);
                if (bus.cmd_go || bus.cmd_stop || bus.frame_err || (bus.rdy && !p_rdy) || bus.rx_data != p_data) begin
                    ev_cnt++;
                    ev_cyc = cyc;
                    if (q.size() == 0) begin
                        chk("unexpected_event", {bus.rx_data, bus.rdy, bus.cmd_go, bus.cmd_stop, bus.frame_err}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("ev_rx_data", bus.rx_data, e.d);
                        chk("ev_rdy", bus.rdy, e.rdy);
                        chk("ev_cmd_go", bus.cmd_go, e.go);
                        chk("ev_cmd_stop", bus.cmd_stop, e.stop);
                        chk("ev_frame_err", bus.frame_err, e.ferr);
                    end
                end
            end
            p_pulse = bus.cmd_go | bus.cmd_stop | bus.frame_err;
            p_data = bus.rx_data;
            p_rdy = bus.rdy;
            p_rst = rst;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RX = 1'b1;
        bus.clr_rdy = 1'b0;
        repeat (4) tick();
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rdy", bus.rdy, 1'b0);
        chk("rst_cmd_go", bus.cmd_go, 1'b0);
        chk("rst_cmd_stop", bus.cmd_stop, 1'b0);
        chk("rst_frame_err", bus.frame_err, 1'b0);
        rst = 1'b0;
        idle(BAUD);

        push(8'h47, 1'b1, 1'b1, 1'b0, 1'b0);
        ev_before = ev_cnt;
        send(8'h47, 1'b1, 0);
        chk("g_event_seen", ev_cnt - ev_before, 1);
        lat = ev_cyc - c0;
        chk("g_latency_ok", lat <= LAT_MAX, 1'b1);
        chk("g_rdy_held", bus.rdy, 1'b1);
        clear_rdy();
        chk("g_rdy_cleared", bus.rdy, 1'b0);

        push(8'h53, 1'b1, 1'b0, 1'b1, 1'b0);
        send(8'h53, 1'b1, 0);
        push(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 0);
        chk("overrun_data", bus.rx_data, 8'hA5);
        chk("overrun_rdy", bus.rdy, 1'b1);
        clear_rdy();

        bus.RX = 1'b0;
        repeat (BAUD / 4) tick();
        idle(2 * BAUD);
        chk("glitch_rx_data", bus.rx_data, 8'hA5);
        chk("glitch_rdy", bus.rdy, 1'b0);

`ifdef UART_CMD_RX_FRAME_ERR_EN
        push(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h47, 1'b0, 0);
        chk("ferr_rdy", bus.rdy, 1'b0);
        chk("ferr_rx_data", bus.rx_data, 8'hA5);
`else
        push(8'h47, 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h47, 1'b0, 0);
        chk("nostop_rdy", bus.rdy, 1'b1);
        chk("nostop_rx_data", bus.rx_data, 8'h47);
`endif
        clear_rdy();

        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < BAUD; k++) begin
                bus.RX = (b == 0) ? 1'b0 : 1'((8'h53 >> (b - 1)) & 8'h01);
                tick();
            end
        end
        bus.RX = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rx_data", bus.rx_data, 8'h00);
        chk("midrst_rdy", bus.rdy, 1'b0);
        chk("midrst_pulses", {bus.cmd_go, bus.cmd_stop, bus.frame_err}, 3'b000);
        repeat (3 * BAUD) tick();
        chk("low_after_rst_no_event", bus.rx_data, 8'h00);
        idle(BAUD);
        push(8'h53, 1'b1, 1'b0, 1'b1, 1'b0);
        send(8'h53, 1'b1, 0);

        push(8'h47, 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h47, 1'b1, lat);
        chk("coincide_rdy_later", bus.rdy, 1'b1);
        clear_rdy();
        chk("coincide_rdy_cleared", bus.rdy, 1'b0);

        idle(BAUD);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
